// File: rtl/frame_line_counter_if.sv
// frame_line_counter_if: strobe inputs and timing outputs of the
// line/frame counter, bundled for the controller and the counter.
interface frame_line_counter_if #(
  parameter int LINE_W  = 6,
  parameter int FRAME_W = 12
);
  logic               enb;
  logic               new_line;
  logic               frame_start;
  logic [LINE_W-1:0]  line_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               field;
  logic               active;
  logic               blank;
  logic               end_frame;
  logic               busy;

  modport master (
    output enb,
    output new_line,
    output frame_start,
    input  line_cnt,
    input  frame_cnt,
    input  field,
    input  active,
    input  blank,
    input  end_frame,
    input  busy
  );

  modport slave (
    input  enb,
    input  new_line,
    input  frame_start,
    output line_cnt,
    output frame_cnt,
    output field,
    output active,
    output blank,
    output end_frame,
    output busy
  );
endinterface

// File: rtl/frame_line_counter.sv
// frame_line_counter: counts qualified line strobes, splits each frame
// into active/blank lines, keeps a wrapping frame count, optional one-shot.
module frame_line_counter #(
  parameter int ACTIVE_LINES = 32,
  parameter int BLANK_LINES  = 0,
  parameter int LINE_W       = 6,
  parameter int FRAME_W      = 12,
  parameter bit ONE_SHOT     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  frame_line_counter_if.slave bus
);

  localparam int TOTAL = ACTIVE_LINES + BLANK_LINES;
  localparam logic [LINE_W-1:0] LAST_ACT =
    LINE_W'(ACTIVE_LINES - 1);
  localparam logic [LINE_W-1:0] LAST_TOT =
    LINE_W'(TOTAL - 1);
  localparam bit HAS_BLANK = (BLANK_LINES > 0);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK,
    DONE
  } state_t;

  state_t             state;
  logic [LINE_W-1:0]  line_cnt;
  logic [FRAME_W-1:0] frame_cnt;
  logic               end_frame;
  logic               active;
  logic               blank;
  logic               busy;

  logic q;
  logic at_last_act;
  logic at_last_tot;
  logic frame_done;

  // The terminating strobe is the last active line when there is no
  // blanking, otherwise the last blanking line.
  always_comb begin
    q           = bus.enb & bus.new_line;
    at_last_act = (line_cnt == LAST_ACT);
    at_last_tot = (line_cnt == LAST_TOT);
    frame_done  = 1'b0;
    case (state)
      ACTIVE:  frame_done = q & at_last_act & ~HAS_BLANK;
      BLANK:   frame_done = q & at_last_tot;
      default: frame_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      line_cnt  <= '0;
      frame_cnt <= '0;
      end_frame <= 1'b0;
      active    <= 1'b0;
      blank     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      end_frame <= 1'b0;
      if (bus.frame_start) begin
        state    <= IDLE;
        line_cnt <= '0;
        active   <= 1'b0;
        blank    <= 1'b0;
        busy     <= 1'b0;
      end else if (frame_done) begin
        line_cnt  <= '0;
        frame_cnt <= frame_cnt + 1'b1;
        end_frame <= 1'b1;
        blank     <= 1'b0;
        if (ONE_SHOT) begin
          state  <= DONE;
          active <= 1'b0;
          busy   <= 1'b0;
        end else begin
          state  <= ACTIVE;
          active <= 1'b1;
          busy   <= 1'b1;
        end
      end else if (q) begin
        case (state)
          IDLE: begin
            state    <= ACTIVE;
            line_cnt <= '0;
            active   <= 1'b1;
            blank    <= 1'b0;
            busy     <= 1'b1;
          end
          ACTIVE: begin
            line_cnt <= line_cnt + 1'b1;
            if (at_last_act) begin
              state  <= BLANK;
              active <= 1'b0;
              blank  <= 1'b1;
            end
          end
          BLANK: begin
            line_cnt <= line_cnt + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.line_cnt  = line_cnt;
  assign bus.frame_cnt = frame_cnt;
  assign bus.field     = frame_cnt[0];
  assign bus.active    = active;
  assign bus.blank     = blank;
  assign bus.end_frame = end_frame;
  assign bus.busy      = busy;

endmodule
